sprite_compositor: RTL and testbench

Parametrised pixel compositor between the game/text logic and vga_sync. It blends NUM_SPRITES square player sprites over a theme-selected foreground/background. Per-sprite position, enable and colour are written through a shadow register file. The shadow file is copied to the active set once per frame, so sprites never tear. Same-pixel sprite overlaps are detected, latched per frame and counted as hits.

---
 rtl/sprite_pkg.sv | 52 +++++
 rtl/sprite_hit.sv | 36 +++
 rtl/sprite_compositor.sv | 159 +++++++++++++++
 tb/tb_sprite_compositor.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types, theme colour table and {R,G,B} helpers for the sprite compositor.
package sprite_pkg;

    localparam int SPR_COORD_W     = 10;
    localparam int SPR_COLOR_W     = 10;
    localparam int DEF_SPRITE_SIZE = 6;
    localparam int RGB_W           = 3 * SPR_COLOR_W;

    typedef logic [SPR_COLOR_W-1:0] chan_t;
    typedef logic [RGB_W-1:0]       rgb_t;

    // One sprite register: enable, top-left corner and packed colour.
    typedef struct packed {
        logic                   en;
        logic [SPR_COORD_W-1:0] x;
        logic [SPR_COORD_W-1:0] y;
        rgb_t                   rgb;
    } sprite_t;

    // Theme background colours, indexed by theme_sel.
    localparam rgb_t THEME_BG [4] = '{
        {10'd0,    10'd0,    10'd0},
        {10'd1000, 10'd1000, 10'd0},
        {10'd1000, 10'd650,  10'd0},
        {10'd600,  10'd0,    10'd0}
    };

    // Theme foreground (glyph) colours, indexed by theme_sel.
    localparam rgb_t THEME_FG [4] = '{
        {10'd1000, 10'd1000, 10'd1000},
        {10'd0,    10'd750,  10'd50},
        {10'd0,    10'd0,    10'd0},
        {10'd1000, 10'd1000, 10'd1000}
    };

    function automatic rgb_t pack_rgb(input chan_t r, input chan_t g, input chan_t b);
        return {r, g, b};
    endfunction

    function automatic chan_t rgb_red(input rgb_t w);
        return w[RGB_W-1 -: SPR_COLOR_W];
    endfunction

    function automatic chan_t rgb_green(input rgb_t w);
        return w[2*SPR_COLOR_W-1 -: SPR_COLOR_W];
    endfunction

    function automatic chan_t rgb_blue(input rgb_t w);
        return w[SPR_COLOR_W-1:0];
    endfunction

endpackage

// File: rtl/sprite_hit.sv
// Combinational hit test for one square sprite. Coordinates are widened by
// one bit so a sprite hanging off the right/bottom edge is clipped instead of
// wrapping around to coordinate 0.
module sprite_hit #(
    parameter int COORD_W     = 10,
    parameter int SPRITE_SIZE = 6
) (
    input  logic               en,
    input  logic [COORD_W-1:0] sx,
    input  logic [COORD_W-1:0] sy,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic               hit
);

    localparam logic [COORD_W:0] SPAN = (COORD_W+1)'(SPRITE_SIZE - 1);

    logic [COORD_W:0] x_lo_s;
    logic [COORD_W:0] x_hi_s;
    logic [COORD_W:0] y_lo_s;
    logic [COORD_W:0] y_hi_s;
    logic [COORD_W:0] px_s;
    logic [COORD_W:0] py_s;

    assign x_lo_s = {1'b0, sx};
    assign y_lo_s = {1'b0, sy};
    assign x_hi_s = x_lo_s + SPAN;
    assign y_hi_s = y_lo_s + SPAN;
    assign px_s   = {1'b0, px};
    assign py_s   = {1'b0, py};

    assign hit = en
               & (px_s >= x_lo_s) & (px_s <= x_hi_s)
               & (py_s >= y_lo_s) & (py_s <= y_hi_s);

endmodule

// File: rtl/sprite_compositor.sv
// Sprite compositor: double-buffered sprite registers, two-stage pixel
// pipeline (hit test, priority select) and per-frame collision tracking.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = SPR_COORD_W,
    parameter int COLOR_W     = SPR_COLOR_W,
    parameter int SPRITE_SIZE = DEF_SPRITE_SIZE,
    parameter int HIT_W       = 4
) (
    input  logic                           iCLK,
    input  logic                           iRST_N,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_SPRITES)-1:0] cfg_idx,
    input  logic                           cfg_en,
    input  logic [COORD_W-1:0]             cfg_x,
    input  logic [COORD_W-1:0]             cfg_y,
    input  logic [3*COLOR_W-1:0]           cfg_rgb,
    input  logic [1:0]                     theme_sel,
    input  logic                           frame_start,
    input  logic [COORD_W-1:0]             px,
    input  logic [COORD_W-1:0]             py,
    input  logic                           glyph_on,
    output logic [COLOR_W-1:0]             oRed,
    output logic [COLOR_W-1:0]             oGreen,
    output logic [COLOR_W-1:0]             oBlue,
    output logic [NUM_SPRITES-1:0]         collide_flags,
    output logic [HIT_W-1:0]               hit_count
);

    localparam int               IDX_W = $clog2(NUM_SPRITES);
    localparam int               CNT_W = $clog2(NUM_SPRITES + 1);
    localparam logic [IDX_W:0]   NUM_S = (IDX_W+1)'(NUM_SPRITES);

    sprite_t                shadow_r [NUM_SPRITES];
    sprite_t                active_r [NUM_SPRITES];

    logic                   idx_ok_s;
    logic [NUM_SPRITES-1:0] hit_s;
    logic [NUM_SPRITES-1:0] hit_r;
    logic [CNT_W-1:0]       ones_s;
    logic                   overlap_s;
    logic [NUM_SPRITES-1:0] overlap_vec_s;
    logic [NUM_SPRITES-1:0] frame_flags_s;
    logic [NUM_SPRITES-1:0] acc_r;
    logic [NUM_SPRITES-1:0] flags_r;
    logic [HIT_W-1:0]       hit_count_r;
    logic                   glyph_r;
    logic [1:0]             theme_r;
    rgb_t                   pix_s;
    logic [COLOR_W-1:0]     red_r;
    logic [COLOR_W-1:0]     green_r;
    logic [COLOR_W-1:0]     blue_r;

    assign idx_ok_s = ({1'b0, cfg_idx} < NUM_S);

    // Shadow file takes config writes; active file copies the pre-write shadow at frame start.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_r[i] <= '0;
                active_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (frame_start) begin
                    active_r[i] <= shadow_r[i];
                end
                if (cfg_we && idx_ok_s && (cfg_idx == IDX_W'(i))) begin
                    shadow_r[i] <= sprite_t'({cfg_en, cfg_x, cfg_y, cfg_rgb});
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        sprite_hit #(
            .COORD_W     (COORD_W),
            .SPRITE_SIZE (SPRITE_SIZE)
        ) u_hit (
            .en  (active_r[g].en),
            .sx  (active_r[g].x),
            .sy  (active_r[g].y),
            .px  (px),
            .py  (py),
            .hit (hit_s[g])
        );
    end

    // Count simultaneous hits; two or more sprites on one pixel is an overlap.
    always_comb begin
        ones_s = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            ones_s = ones_s + CNT_W'(hit_s[i]);
        end
        overlap_s     = (ones_s >= CNT_W'(2));
        overlap_vec_s = overlap_s ? hit_s : '0;
        frame_flags_s = acc_r | overlap_vec_s;
    end

    // Stage 1: register hit vector and the per-pixel context that travels with it.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            hit_r   <= '0;
            glyph_r <= 1'b0;
            theme_r <= 2'd0;
        end else begin
            hit_r   <= hit_s;
            glyph_r <= glyph_on;
            theme_r <= theme_sel;
        end
    end

    // Sticky overlap accumulator, per-frame flag snapshot and saturating hit counter.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            acc_r       <= '0;
            flags_r     <= '0;
            hit_count_r <= '0;
        end else if (frame_start) begin
            flags_r <= frame_flags_s;
            acc_r   <= '0;
            if ((frame_flags_s != '0) && (hit_count_r != {HIT_W{1'b1}})) begin
                hit_count_r <= hit_count_r + HIT_W'(1);
            end
        end else begin
            acc_r <= frame_flags_s;
        end
    end

    // Stage 2 select: lowest-index hit sprite wins, otherwise theme fg/bg.
    always_comb begin
        pix_s = glyph_r ? THEME_FG[theme_r] : THEME_BG[theme_r];
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            pix_s = hit_r[i] ? active_r[i].rgb : pix_s;
        end
    end

    // Register the selected colour onto the outputs.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            red_r   <= '0;
            green_r <= '0;
            blue_r  <= '0;
        end else begin
            red_r   <= rgb_red(pix_s);
            green_r <= rgb_green(pix_s);
            blue_r  <= rgb_blue(pix_s);
        end
    end

    assign oRed          = red_r;
    assign oGreen        = green_r;
    assign oBlue         = blue_r;
    assign collide_flags = flags_r;
    assign hit_count     = hit_count_r;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios plus random
// sprite layouts, checked against a pixel-level behavioural model.
module tb_sprite_compositor;

    localparam int N  = 4;
    localparam int SS = 6;

    logic        iCLK;
    logic        iRST_N;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic        cfg_en;
    logic [9:0]  cfg_x;
    logic [9:0]  cfg_y;
    logic [29:0] cfg_rgb;
    logic [1:0]  theme_sel;
    logic        frame_start;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        glyph_on;
    logic [9:0]  oRed;
    logic [9:0]  oGreen;
    logic [9:0]  oBlue;
    logic [3:0]  collide_flags;
    logic [3:0]  hit_count;

    sprite_compositor dut (
        .iCLK          (iCLK),
        .iRST_N        (iRST_N),
        .cfg_we        (cfg_we),
        .cfg_idx       (cfg_idx),
        .cfg_en        (cfg_en),
        .cfg_x         (cfg_x),
        .cfg_y         (cfg_y),
        .cfg_rgb       (cfg_rgb),
        .theme_sel     (theme_sel),
        .frame_start   (frame_start),
        .px            (px),
        .py            (py),
        .glyph_on      (glyph_on),
        .oRed          (oRed),
        .oGreen        (oGreen),
        .oBlue         (oBlue),
        .collide_flags (collide_flags),
        .hit_count     (hit_count)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // reference model state
    int          sh_en [N];
    int          sh_x  [N];
    int          sh_y  [N];
    logic [29:0] sh_rgb[N];
    int          ac_en [N];
    int          ac_x  [N];
    int          ac_y  [N];
    logic [29:0] ac_rgb[N];
    logic [3:0]  m_acc;
    logic [3:0]  m_flags;
    int          m_hits;
    logic [29:0] th_bg[4];
    logic [29:0] th_fg[4];
    logic [29:0] exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] mk(input int r, input int g, input int b);
        logic [9:0] r10, g10, b10;
        r10 = 10'(r);
        g10 = 10'(g);
        b10 = 10'(b);
        return {r10, g10, b10};
    endfunction

    function automatic logic [3:0] model_hits(input int x, input int y);
        logic [3:0] h;
        h = 4'd0;
        for (int i = 0; i < N; i++) begin
            if (ac_en[i] != 0 && x >= ac_x[i] && x <= ac_x[i] + SS - 1 &&
                y >= ac_y[i] && y <= ac_y[i] + SS - 1)
                h[i] = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [29:0] exp_colour(input int x, input int y, input int g, input int t);
        logic [3:0] h;
        h = model_hits(x, y);
        for (int i = 0; i < N; i++) begin
            if (h[i]) return ac_rgb[i];
        end
        return (g != 0) ? th_fg[t] : th_bg[t];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh_en[i] = 0; sh_x[i] = 0; sh_y[i] = 0; sh_rgb[i] = 30'd0;
            ac_en[i] = 0; ac_x[i] = 0; ac_y[i] = 0; ac_rgb[i] = 30'd0;
        end
        m_acc   = 4'd0;
        m_flags = 4'd0;
        m_hits  = 0;
        exp_q.delete();
    endtask

    // Advance one clock: apply the behavioural rules for this edge, then wait for it.
    task automatic cycle();
        logic [3:0] h;
        logic [3:0] ov;
        h  = model_hits(int'(px), int'(py));
        ov = ($countones(h) >= 2) ? h : 4'd0;
        if (frame_start) begin
            m_flags = m_acc | ov;
            if (m_flags != 4'd0 && m_hits < 15) m_hits++;
            m_acc = 4'd0;
            for (int i = 0; i < N; i++) begin
                ac_en[i] = sh_en[i]; ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_rgb[i] = sh_rgb[i];
            end
        end else begin
            m_acc = m_acc | ov;
        end
        if (cfg_we) begin
            sh_en[cfg_idx]  = int'(cfg_en);
            sh_x[cfg_idx]   = int'(cfg_x);
            sh_y[cfg_idx]   = int'(cfg_y);
            sh_rgb[cfg_idx] = cfg_rgb;
        end
        @(posedge iCLK);
        #1;
    endtask

    task automatic cfg_write(input int idx, input int en, input int x, input int y,
                             input logic [29:0] rgb, input int fs);
        cfg_idx     = 2'(idx);
        cfg_en      = (en != 0);
        cfg_x       = 10'(x);
        cfg_y       = 10'(y);
        cfg_rgb     = rgb;
        cfg_we      = 1'b1;
        frame_start = (fs != 0);
        cycle();
        cfg_we      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic frame_pulse(input string tag);
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        check_val({tag, "_flags"}, 32'(collide_flags), 32'(m_flags));
        check_val({tag, "_hitcnt"}, 32'(hit_count), 32'(m_hits));
    endtask

    // Drive one pixel; the pixel driven on the previous step is checked now (2-cycle latency).
    task automatic step(input string tag, input int x, input int y, input int g, input int t);
        px        = 10'(x);
        py        = 10'(y);
        glyph_on  = (g != 0);
        theme_sel = 2'(t);
        exp_q.push_back(exp_colour(x, y, g, t));
        cycle();
        if (exp_q.size() == 2) check_val({tag, "_pix"}, 32'({oRed, oGreen, oBlue}), 32'(exp_q.pop_front()));
    endtask

    task automatic flush(input string tag);
        cycle();
        if (exp_q.size() > 0) check_val({tag, "_pix"}, 32'({oRed, oGreen, oBlue}), 32'(exp_q.pop_front()));
        exp_q.delete();
    endtask

    initial begin
        th_bg[0] = mk(0, 0, 0);       th_fg[0] = mk(1000, 1000, 1000);
        th_bg[1] = mk(1000, 1000, 0); th_fg[1] = mk(0, 750, 50);
        th_bg[2] = mk(1000, 650, 0);  th_fg[2] = mk(0, 0, 0);
        th_bg[3] = mk(600, 0, 0);     th_fg[3] = mk(1000, 1000, 1000);
        model_reset();

        iRST_N = 1'b0; cfg_we = 1'b0; cfg_idx = 2'd0; cfg_en = 1'b0; cfg_x = 10'd0;
        cfg_y = 10'd0; cfg_rgb = 30'd0; theme_sel = 2'd0; frame_start = 1'b0;
        px = 10'd0; py = 10'd0; glyph_on = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        check_val("rst_pix", 32'({oRed, oGreen, oBlue}), 32'd0);
        check_val("rst_flags", 32'(collide_flags), 32'd0);
        check_val("rst_hitcnt", 32'(hit_count), 32'd0);
        iRST_N = 1'b1;
        cycle();

        // single blue sprite, scan across its row including both neighbours
        cfg_write(0, 1, 100, 50, mk(0, 0, 750), 0);
        frame_pulse("a_frame");
        for (int x = 99; x <= 106; x++) step("a_scan", x, 50, 0, 0);
        flush("a_scan");
        step("a_glyph", 99, 50, 1, 3);
        step("a_in", 105, 55, 1, 3);
        step("a_below", 105, 56, 0, 2);
        flush("a_end");

        // overlap: sprite 0 wins, flags latched on the next frame start
        cfg_write(1, 1, 103, 52, mk(1000, 0, 0), 0);
        frame_pulse("b_frame0");
        step("b_ovl", 104, 53, 0, 1);
        step("b_s1", 108, 57, 0, 1);
        flush("b_ovl");
        frame_pulse("b_frame1");
        check_val("b_flags_const", 32'(collide_flags), 32'd3);
        check_val("b_hit_const", 32'(hit_count), 32'd1);
        frame_pulse("b_frame2");

        // write without a frame start is not visible; write coinciding with frame start lands a frame later
        cfg_write(0, 1, 300, 300, mk(0, 1000, 0), 0);
        step("c_old", 100, 50, 0, 0);
        step("c_old2", 300, 300, 0, 0);
        flush("c_old");
        cfg_write(0, 1, 200, 200, mk(0, 1000, 0), 1);
        step("c_same0", 300, 300, 0, 0);
        step("c_same1", 200, 200, 0, 0);
        step("c_same2", 100, 50, 0, 0);
        flush("c_same");
        frame_pulse("c_frame");
        step("c_new0", 200, 200, 0, 0);
        step("c_new1", 300, 300, 0, 0);
        flush("c_new");

        // right-edge clipping: no wrap onto px 0..1
        cfg_write(0, 0, 0, 0, 30'd0, 0);
        cfg_write(1, 0, 0, 0, 30'd0, 0);
        cfg_write(2, 1, 1020, 300, mk(500, 500, 500), 0);
        frame_pulse("d_frame");
        for (int x = 1018; x <= 1023; x++) step("d_edge", x, 300, 0, 0);
        for (int x = 0; x <= 2; x++) step("d_wrap", x, 300, 1, 0);
        flush("d_edge");

        // random layouts concentrated in small regions so overlaps and edge cases occur
        for (int r = 0; r < 40; r++) begin
            int nw;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) begin
                int xr;
                xr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1010, 1023)) : int'($urandom_range(0, 40));
                cfg_write(int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0) ? 1 : 0,
                          xr, int'($urandom_range(0, 40)), 30'($urandom), 0);
            end
            frame_pulse("r_frame");
            for (int s = 0; s < 12; s++) begin
                int xs;
                xs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1008, 1023)) : int'($urandom_range(0, 50));
                step("r_scan", xs, int'($urandom_range(0, 50)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)));
            end
            flush("r_scan");
        end

        // saturation of the hit counter
        cfg_write(0, 1, 10, 10, mk(1, 2, 3), 0);
        cfg_write(1, 1, 12, 12, mk(4, 5, 6), 0);
        frame_pulse("s_setup");
        for (int f = 0; f < 17; f++) begin
            step("s_ovl", 13, 13, 0, 0);
            flush("s_ovl");
            frame_pulse("s_frame");
        end
        check_val("s_sat", 32'(hit_count), 32'd15);

        // reset in the middle of a line
        step("m_pre", 13, 13, 0, 0);
        step("m_pre", 11, 11, 0, 0);
        @(posedge iCLK);
        #2;
        iRST_N = 1'b0;
        #1;
        check_val("m_rst_pix", 32'({oRed, oGreen, oBlue}), 32'd0);
        check_val("m_rst_hitcnt", 32'(hit_count), 32'd0);
        check_val("m_rst_flags", 32'(collide_flags), 32'd0);
        model_reset();
        @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
        frame_pulse("m_frame");
        step("m_after", 13, 13, 0, 1);
        step("m_after", 10, 10, 1, 1);
        step("m_after", 1020, 300, 0, 3);
        flush("m_after");
        check_val("m_after_hitcnt", 32'(hit_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
